// File: rtl/clahe_pkg.sv
// Shared CLAHE types and size helpers.
// Used by the tile LUT engine and the interpolation mapper.
package clahe_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_ACCUM,
        ST_CLIP,
        ST_EMIT
    } state_t;

    function automatic int bins_of(input int pixel_w);
        return 1 << pixel_w;
    endfunction

    function automatic int tile_pix_of(input int tile_w, input int tile_h);
        return tile_w * tile_h;
    endfunction

    function automatic int cnt_w_of(input int tile_pix);
        return $clog2(tile_pix) + 1;
    endfunction

endpackage

// File: rtl/clahe_hist_ram.sv
// Histogram storage: simple dual-port RAM, registered write,
// synchronous read with one cycle of latency, array not reset.
module clahe_hist_ram
    import clahe_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/clahe_tile_lut.sv
// Per-tile CLAHE LUT engine: histogram, clip, redistribute,
// then stream the normalised CDF as a lookup table.
module clahe_tile_lut
    import clahe_pkg::*;
#(
    parameter int PIXEL_W = 8,
    parameter int TILE_W  = 32,
    parameter int TILE_H  = 32,
    parameter int CNT_W   = cnt_w_of(tile_pix_of(TILE_W, TILE_H))
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   clip_limit,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PIXEL_W-1:0] in_pixel,
    output logic               lut_valid,
    input  logic               lut_ready,
    output logic [PIXEL_W-1:0] lut_idx,
    output logic [PIXEL_W-1:0] lut_data,
    output logic               busy,
    output logic               tile_done
);

    localparam int BINS     = bins_of(PIXEL_W);
    localparam int TILE_PIX = tile_pix_of(TILE_W, TILE_H);
    localparam int SH       = $clog2(TILE_PIX);
    localparam int CW       = (CNT_W > PIXEL_W + 1) ? CNT_W : PIXEL_W + 1;
    localparam int PW2      = CNT_W + PIXEL_W;

    localparam logic [CW-1:0]      BINS_C  = CW'(BINS);
    localparam logic [CW-1:0]      BINS_M1 = CW'(BINS - 1);
    localparam logic [CW-1:0]      PIX_M1  = CW'(TILE_PIX - 1);
    localparam logic [PIXEL_W-1:0] IDX_END = PIXEL_W'(BINS - 1);

    if (TILE_PIX != (1 << SH)) begin : g_pow2_chk
        $error("TILE_W*TILE_H must be a power of two");
    end

    state_t state, state_nxt;

    logic [CW-1:0]      cnt;
    logic [CNT_W-1:0]   clip_q;
    logic               m_v, m_clip;
    logic [PIXEL_W-1:0] m_addr;
    logic               w_v;
    logic [PIXEL_W-1:0] w_addr;
    logic [CNT_W-1:0]   w_data;
    logic [CNT_W-1:0]   excess, perbin;
    logic [PIXEL_W-1:0] rem;
    logic               e_v;
    logic [PIXEL_W-1:0] e_idx;
    logic [CNT_W-1:0]   cdf;

    logic               we;
    logic [PIXEL_W-1:0] waddr, raddr;
    logic [CNT_W-1:0]   wdata, rdata;

    logic               acc, hs, ld, e_adv, m_over;
    logic [CNT_W-1:0]   m_old, m_new, excess_nxt, h, cdf_nxt;
    logic [PW2-1:0]     prod;

    clahe_hist_ram #(
        .DEPTH (BINS),
        .AW    (PIXEL_W),
        .DW    (CNT_W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    assign in_ready = (state == ST_ACCUM);
    assign busy     = (state != ST_IDLE);
    assign acc      = in_valid && in_ready;
    assign hs       = lut_valid && lut_ready;

    // Read-modify-write stage shared by ACCUM and CLIP; the previous
    // write is forwarded because the RAM read misses it by one cycle.
    assign m_old  = (w_v && w_addr == m_addr) ? w_data : rdata;
    assign m_over = (clip_q != '0) && (m_old > clip_q);
    assign m_new  = m_clip ? (m_over ? clip_q : m_old)
                           : m_old + CNT_W'(1);
    assign excess_nxt = excess +
        ((m_v && m_clip && m_over) ? m_old - clip_q : '0);

    assign ld    = e_v && (!lut_valid || lut_ready);
    assign e_adv = (state == ST_EMIT) && (!e_v || ld) && (cnt < BINS_C);
    assign h       = rdata + perbin + CNT_W'(e_idx < rem);
    assign cdf_nxt = cdf + h;
    assign prod    = PW2'(cdf_nxt) * PW2'(BINS - 1);

    always_comb begin
        we    = 1'b0;
        waddr = m_addr;
        wdata = m_new;
        raddr = in_pixel;
        unique case (state)
            ST_CLEAR: begin
                we    = 1'b1;
                waddr = cnt[PIXEL_W-1:0];
                wdata = '0;
            end
            ST_CLIP: raddr = cnt[PIXEL_W-1:0];
            ST_EMIT: begin
                we    = hs;
                waddr = lut_idx;
                wdata = '0;
                raddr = e_adv ? cnt[PIXEL_W-1:0] : e_idx;
            end
            default: ;
        endcase
        if (m_v) begin
            we    = 1'b1;
            waddr = m_addr;
            wdata = m_new;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_CLEAR: if (cnt == BINS_M1) state_nxt = ST_IDLE;
            ST_IDLE:  if (start) state_nxt = ST_ACCUM;
            ST_ACCUM: if (acc && cnt == PIX_M1) state_nxt = ST_CLIP;
            ST_CLIP:  if (cnt == BINS_C) state_nxt = ST_EMIT;
            ST_EMIT:  if (hs && lut_idx == IDX_END) state_nxt = ST_IDLE;
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_CLEAR;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            clip_q    <= '0;
            m_v       <= 1'b0;
            m_clip    <= 1'b0;
            m_addr    <= '0;
            w_v       <= 1'b0;
            w_addr    <= '0;
            w_data    <= '0;
            excess    <= '0;
            perbin    <= '0;
            rem       <= '0;
            e_v       <= 1'b0;
            e_idx     <= '0;
            cdf       <= '0;
            lut_valid <= 1'b0;
            lut_idx   <= '0;
            lut_data  <= '0;
            tile_done <= 1'b0;
        end else begin
            w_v       <= m_v;
            w_addr    <= m_addr;
            w_data    <= m_new;
            m_v       <= 1'b0;
            tile_done <= 1'b0;
            unique case (state)
                ST_CLEAR: begin
                    cnt <= (state_nxt == ST_IDLE) ? '0 : cnt + 1'b1;
                end
                ST_IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        clip_q <= clip_limit;
                        excess <= '0;
                    end
                end
                ST_ACCUM: begin
                    m_v    <= acc;
                    m_clip <= 1'b0;
                    m_addr <= in_pixel;
                    if (acc) cnt <= (state_nxt == ST_CLIP) ? '0 : cnt + 1'b1;
                end
                ST_CLIP: begin
                    m_v    <= (cnt < BINS_C);
                    m_clip <= 1'b1;
                    m_addr <= cnt[PIXEL_W-1:0];
                    excess <= excess_nxt;
                    cnt    <= cnt + 1'b1;
                    if (state_nxt == ST_EMIT) begin
                        perbin <= excess_nxt >> PIXEL_W;
                        rem    <= excess_nxt[PIXEL_W-1:0];
                        cnt    <= '0;
                        cdf    <= '0;
                        e_v    <= 1'b0;
                    end
                end
                ST_EMIT: begin
                    if (e_adv) begin
                        e_v   <= 1'b1;
                        e_idx <= cnt[PIXEL_W-1:0];
                        cnt   <= cnt + 1'b1;
                    end else if (ld) begin
                        e_v <= 1'b0;
                    end
                    if (ld) begin
                        lut_valid <= 1'b1;
                        lut_idx   <= e_idx;
                        lut_data  <= PIXEL_W'(prod >> SH);
                        cdf       <= cdf_nxt;
                    end else if (hs) begin
                        lut_valid <= 1'b0;
                    end
                    if (state_nxt == ST_IDLE) tile_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clahe_tile_lut.sv
// Directed bench for clahe_tile_lut: scoreboarded LUT entries,
// backpressure, mid-tile reset and ignored starts.
module tb_clahe_tile_lut;

    localparam int PW   = 8;
    localparam int CW   = 11;
    localparam int TP   = 1024;
    localparam int BINS = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] clip_limit = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] in_pixel = '0;
    logic          lut_valid;
    logic          lut_ready = 1'b0;
    logic [PW-1:0] lut_idx;
    logic [PW-1:0] lut_data;
    logic          busy;
    logic          tile_done;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int pix[TP];
    int got[BINS];
    int ref_lut[BINS];

    always #5 clk = ~clk;

    clahe_tile_lut #(
        .PIXEL_W (PW),
        .TILE_W  (32),
        .TILE_H  (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .clip_limit (clip_limit),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .lut_valid  (lut_valid),
        .lut_ready  (lut_ready),
        .lut_idx    (lut_idx),
        .lut_data   (lut_data),
        .busy       (busy),
        .tile_done  (tile_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input int mode);
        for (int k = 0; k < TP; k++) begin
            case (mode)
                0:       pix[k] = k % BINS;
                1:       pix[k] = 128;
                default: pix[k] = $urandom_range(0, 63);
            endcase
        end
    endtask

    task automatic model(input int clip);
        int hist[BINS];
        int ex, pb, rm, cdf, h;
        for (int i = 0; i < BINS; i++) hist[i] = 0;
        for (int k = 0; k < TP; k++) hist[pix[k]]++;
        ex = 0;
        if (clip != 0) begin
            for (int i = 0; i < BINS; i++) begin
                if (hist[i] > clip) begin
                    ex += hist[i] - clip;
                    hist[i] = clip;
                end
            end
        end
        pb = ex / BINS;
        rm = ex % BINS;
        cdf = 0;
        for (int i = 0; i < BINS; i++) begin
            h = hist[i] + pb + ((i < rm) ? 1 : 0);
            cdf += h;
            exp_q.push_back((cdf * (BINS - 1)) / TP);
        end
    endtask

    task automatic wait_idle(input string nm);
        int cyc = 0;
        while (busy && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, " idle"}, busy, 0);
    endtask

    task automatic run_tile(input string nm, input int clip,
                            input bit rv, input bit rr, input bit poke);
        int k, n, cyc;
        bit stalled, sent;
        logic [PW-1:0] pi, pd;
        model(clip);
        @(negedge clk);
        start = 1'b1;
        clip_limit = CW'(clip);
        @(negedge clk);
        start = 1'b0;
        chk({nm, " in_ready_up"}, in_ready, 1);
        k = 0;
        cyc = 0;
        while (k < TP && cyc < 20000) begin
            in_valid = rv ? 1'($urandom_range(0, 1)) : 1'b1;
            in_pixel = PW'(pix[k]);
            if (in_valid && in_ready) k++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk({nm, " pixels_taken"}, k, TP);
        chk({nm, " in_ready_drop"}, in_ready, 0);
        n = 0;
        cyc = 0;
        stalled = 1'b0;
        sent = 1'b0;
        pi = '0;
        pd = '0;
        while (n < BINS && cyc < 20000) begin
            if (stalled) begin
                chk({nm, " hold_valid"}, lut_valid, 1);
                chk({nm, " hold_idx"}, lut_idx, pi);
                chk({nm, " hold_data"}, lut_data, pd);
            end
            lut_ready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
            start = 1'b0;
            if (poke && lut_valid && !sent) begin
                start = 1'b1;
                sent = 1'b1;
            end
            if (lut_valid && lut_ready) begin
                chk({nm, " idx"}, lut_idx, n);
                got[n] = lut_data;
                chk({nm, " lut"}, lut_data,
                    (exp_q.size() > 0) ? exp_q.pop_front() : 32'hdead);
                n++;
            end
            stalled = lut_valid && !lut_ready;
            pi = lut_idx;
            pd = lut_data;
            @(negedge clk);
            cyc++;
        end
        lut_ready = 1'b0;
        start = 1'b0;
        chk({nm, " entries"}, n, BINS);
        chk({nm, " tile_done"}, tile_done, 1);
        chk({nm, " busy_end"}, busy, 0);
        @(negedge clk);
        chk({nm, " done_pulse"}, tile_done, 0);
        chk({nm, " stay_idle"}, busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst in_ready", in_ready, 0);
        chk("rst lut_valid", lut_valid, 0);
        chk("rst lut_idx", lut_idx, 0);
        chk("rst lut_data", lut_data, 0);
        chk("rst tile_done", tile_done, 0);
        chk("rst busy", busy, 1);
        rst_n = 1'b1;
        wait_idle("clear");

        fill(0);
        run_tile("uniform", 20, 0, 0, 1);
        chk("uniform lut0", got[0], 0);
        chk("uniform lut127", got[127], 127);
        chk("uniform lut255", got[255], 255);

        fill(1);
        run_tile("single", 20, 0, 0, 0);
        chk("single lut0", got[0], 0);
        chk("single lut127", got[127], 127);
        chk("single lut128", got[128], 133);
        chk("single lut255", got[255], 255);

        run_tile("bypass", 0, 0, 0, 0);
        chk("bypass lut127", got[127], 0);
        chk("bypass lut128", got[128], 255);
        chk("bypass lut255", got[255], 255);

        fill(2);
        run_tile("rand", 5, 0, 0, 0);
        for (int i = 0; i < BINS; i++) ref_lut[i] = got[i];
        run_tile("stall", 5, 1, 1, 0);
        for (int i = 0; i < BINS; i++) chk("stall vs free", got[i], ref_lut[i]);

        fill(0);
        @(negedge clk);
        start = 1'b1;
        clip_limit = CW'(20);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 500; k++) begin
            in_valid = 1'b1;
            in_pixel = PW'(pix[k]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort in_ready", in_ready, 0);
        chk("abort busy", busy, 1);
        chk("abort lut_valid", lut_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle("reclear");
        run_tile("after_rst", 20, 0, 0, 0);
        chk("after_rst lut0", got[0], 0);
        chk("after_rst lut127", got[127], 127);
        chk("after_rst lut255", got[255], 255);

        fill(1);
        run_tile("b2b", 20, 0, 0, 0);
        chk("b2b lut128", got[128], 133);
        chk("queue empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
